// File: rtl/bram_port_arbiter_if.sv
// Two-requester BRAM access bundle: request/response pairs for the debug host (0)
// and user logic (1), plus the single BRAM command/data port they share.
interface bram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 16
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic                  req0_we;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wdata;
  logic                  rsp0_valid;
  logic [DATA_WIDTH-1:0] rsp0_rdata;

  logic                  req1_valid;
  logic                  req1_ready;
  logic                  req1_we;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wdata;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp1_rdata;

  logic                  bram_en;
  logic                  bram_we;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_wdata;
  logic [DATA_WIDTH-1:0] bram_rdata;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output bram_en, bram_we, bram_addr, bram_wdata,
    input  bram_rdata
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  bram_en, bram_we, bram_addr, bram_wdata,
    output bram_rdata
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port between two requesters; reads are
// tagged through a READ_LATENCY-deep pipeline and returned to their owner.
module bram_port_arbiter #(
  parameter int ADDR_WIDTH   = 14,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  bram_port_arbiter_if.slave bus
);
  logic                    grant0;
  logic                    grant1;
  logic                    accept;
  logic                    ptr_reg;
  logic                    en_reg;
  logic                    we_reg;
  logic                    tag_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [READ_LATENCY-1:0] pipe_valid_reg;
  logic [READ_LATENCY-1:0] pipe_tag_reg;

  // A lone requester wins outright; under contention the pointer decides.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst_in) begin
      if (bus.req0_valid && (!bus.req1_valid || !ptr_reg)) begin
        grant0 = 1'b1;
      end else if (bus.req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign accept         = grant0 | grant1;
  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ptr_reg   <= 1'b0;
      en_reg    <= 1'b0;
      we_reg    <= 1'b0;
      tag_reg   <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      en_reg <= accept;
      we_reg <= grant0 ? bus.req0_we : (grant1 & bus.req1_we);
      if (accept) begin
        ptr_reg   <= grant0;
        tag_reg   <= grant1;
        addr_reg  <= grant0 ? bus.req0_addr  : bus.req1_addr;
        wdata_reg <= grant0 ? bus.req0_wdata : bus.req1_wdata;
      end
    end
  end

  assign bus.bram_en    = en_reg;
  assign bus.bram_we    = we_reg;
  assign bus.bram_addr  = addr_reg;
  assign bus.bram_wdata = wdata_reg;

  // Stage 0 is loaded as the BRAM samples the read, so the last stage lines up
  // with the cycle in which bram_rdata is valid.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pipe_valid_reg <= '0;
      pipe_tag_reg   <= '0;
    end else begin
      for (int i = READ_LATENCY - 1; i > 0; i--) begin
        pipe_valid_reg[i] <= pipe_valid_reg[i-1];
        pipe_tag_reg[i]   <= pipe_tag_reg[i-1];
      end
      pipe_valid_reg[0] <= en_reg & ~we_reg;
      pipe_tag_reg[0]   <= tag_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_rsp
      logic                  valid_reg;
      logic [DATA_WIDTH-1:0] rdata_reg;
      logic                  hit;

      assign hit = pipe_valid_reg[READ_LATENCY-1] &&
                   (pipe_tag_reg[READ_LATENCY-1] == 1'(gi));

      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
          valid_reg <= 1'b0;
          rdata_reg <= '0;
        end else begin
          valid_reg <= hit;
          if (hit) begin
            rdata_reg <= bus.bram_rdata;
          end
        end
      end
    end
  endgenerate

  assign bus.rsp0_valid = gen_rsp[0].valid_reg;
  assign bus.rsp0_rdata = gen_rsp[0].rdata_reg;
  assign bus.rsp1_valid = gen_rsp[1].valid_reg;
  assign bus.rsp1_rdata = gen_rsp[1].rdata_reg;
endmodule
